// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state TMS-steered FSM on TCK,
// with decoded capture/shift/update strobes and falling-edge test_reset/tdo_en.
module tap_controller (
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output logic [3:0] state,
    output logic       tlr_reset,
    output logic       test_reset,
    output logic       ir_capture,
    output logic       ir_shift,
    output logic       ir_update,
    output logic       dr_capture,
    output logic       dr_shift,
    output logic       dr_update,
    output logic       select_ir,
    output logic       tdo_en
);

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SH_DR    = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SH_IR    = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_t;

    tap_state_t cur;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            cur <= TLR;
        end else begin
            case (cur)
                TLR:      cur <= TMS ? TLR    : RTI;
                RTI:      cur <= TMS ? SEL_DR : RTI;
                SEL_DR:   cur <= TMS ? SEL_IR : CAP_DR;
                CAP_DR:   cur <= TMS ? EX1_DR : SH_DR;
                SH_DR:    cur <= TMS ? EX1_DR : SH_DR;
                EX1_DR:   cur <= TMS ? UPD_DR : PAUSE_DR;
                PAUSE_DR: cur <= TMS ? EX2_DR : PAUSE_DR;
                EX2_DR:   cur <= TMS ? UPD_DR : SH_DR;
                UPD_DR:   cur <= TMS ? SEL_DR : RTI;
                SEL_IR:   cur <= TMS ? TLR    : CAP_IR;
                CAP_IR:   cur <= TMS ? EX1_IR : SH_IR;
                SH_IR:    cur <= TMS ? EX1_IR : SH_IR;
                EX1_IR:   cur <= TMS ? UPD_IR : PAUSE_IR;
                PAUSE_IR: cur <= TMS ? EX2_IR : PAUSE_IR;
                EX2_IR:   cur <= TMS ? UPD_IR : SH_IR;
                UPD_IR:   cur <= TMS ? SEL_DR : RTI;
                default:  cur <= TLR;
            endcase
        end
    end

    assign state      = cur;
    assign tlr_reset  = (cur == TLR);
    assign ir_capture = (cur == CAP_IR);
    assign ir_shift   = (cur == SH_IR);
    assign ir_update  = (cur == UPD_IR);
    assign dr_capture = (cur == CAP_DR);
    assign dr_shift   = (cur == SH_DR);
    assign dr_update  = (cur == UPD_DR);

    // SEL_IR is the only IR-column state whose code lacks bit 3
    assign select_ir  = cur[3] ? (cur != RTI && cur != TLR)
                               : (cur == SEL_IR);

    // Falling-edge copies so TDO only ever moves on negedge TCK
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            test_reset <= 1'b1;
            tdo_en     <= 1'b0;
        end else begin
            test_reset <= (cur == TLR);
            tdo_en     <= (cur == SH_IR) || (cur == SH_DR);
        end
    end

endmodule

// File: tb/tb_tap_controller.sv
// Randomized scoreboard bench for tap_controller against a
// table-driven model of the 1149.1 state diagram.
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       TRST = 1'b0;
    logic       TMS = 1'b1;
    logic [3:0] state;
    logic       tlr_reset, test_reset;
    logic       ir_capture, ir_shift, ir_update;
    logic       dr_capture, dr_shift, dr_update;
    logic       select_ir, tdo_en;

    tap_controller dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .state      (state),
        .tlr_reset  (tlr_reset),
        .test_reset (test_reset),
        .ir_capture (ir_capture),
        .ir_shift   (ir_shift),
        .ir_update  (ir_update),
        .dr_capture (dr_capture),
        .dr_shift   (dr_shift),
        .dr_update  (dr_update),
        .select_ir  (select_ir),
        .tdo_en     (tdo_en)
    );

    always #10 TCK = ~TCK;

    localparam logic [3:0] S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR = 4'h2;
    localparam logic [3:0] S_PDR = 4'h3, S_SELIR = 4'h4, S_UPDR = 4'h5;
    localparam logic [3:0] S_CAPDR = 4'h6, S_SELDR = 4'h7, S_EX2IR = 4'h8;
    localparam logic [3:0] S_EX1IR = 4'h9, S_SHIR = 4'hA, S_PIR = 4'hB;
    localparam logic [3:0] S_RTI = 4'hC, S_UPIR = 4'hD, S_CAPIR = 4'hE;
    localparam logic [3:0] S_TLR = 4'hF;

    // Next-state tables transcribed from the state diagram, indexed by code
    logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                              4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                              4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    logic [3:0] q [$];
    logic [3:0] model = S_TLR;
    logic       prev_tr = 1'b1;
    logic       prev_te = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (model state %0h) at %0t",
                     nm, act, exp, model, $time);
        end
    endtask

    function automatic logic [5:0] exp_strobes(input logic [3:0] s);
        exp_strobes = {s == S_CAPIR, s == S_SHIR, s == S_UPIR,
                       s == S_CAPDR, s == S_SHDR, s == S_UPDR};
    endfunction

    function automatic logic is_ir(input logic [3:0] s);
        is_ir = s inside {S_SELIR, S_CAPIR, S_SHIR, S_EX1IR,
                          S_PIR, S_EX2IR, S_UPIR};
    endfunction

    // Driver sits at negedge+2; one call = one TCK cycle
    task automatic step(input logic tms);
        TMS = tms;
        model = tms ? nxt1[model] : nxt0[model];
        q.push_back(model);
        @(negedge TCK);
        #2;
    endtask

    task automatic walk_to(input logic [3:0] target);
        int n = 0;
        while (model != target && n < 400) begin
            step(1'($urandom_range(0, 1)));
            n++;
        end
        if (model != target) begin
            n_fail++;
            $display("FAIL walk_to: stuck at %0h expected %0h", model, target);
        end
    endtask

    task automatic seq(input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) step(bits[i]);
    endtask

    // Async pulse between edges; outputs must react without a clock
    task automatic trst_pulse();
        #1 TRST = 1'b0;
        #1;
        chk("trst_state", int'(state), int'(S_TLR));
        chk("trst_tlr_reset", int'(tlr_reset), 1);
        chk("trst_test_reset", int'(test_reset), 1);
        chk("trst_tdo_en", int'(tdo_en), 0);
        chk("trst_strobes", int'({ir_capture, ir_shift, ir_update,
                                  dr_capture, dr_shift, dr_update}), 0);
        model = S_TLR;
        prev_tr = 1'b1;
        prev_te = 1'b0;
        #2 TRST = 1'b1;
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge TCK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", int'(state), int'(e));
                chk("test_reset_hold", int'(test_reset), int'(prev_tr));
                chk("tdo_en_hold", int'(tdo_en), int'(prev_te));
                chk("tlr_reset", int'(tlr_reset), int'(e == S_TLR));
                chk("strobes", int'({ir_capture, ir_shift, ir_update,
                                     dr_capture, dr_shift, dr_update}),
                    int'(exp_strobes(e)));
                chk("select_ir", int'(select_ir), int'(is_ir(e)));
                chk("onehot", $countones({ir_capture, ir_shift, ir_update,
                                          dr_capture, dr_shift, dr_update}) <= 1
                              ? 1 : 0, 1);
                @(negedge TCK);
                #1;
                prev_tr = (e == S_TLR);
                prev_te = (e == S_SHIR) || (e == S_SHDR);
                chk("test_reset", int'(test_reset), int'(prev_tr));
                chk("tdo_en", int'(tdo_en), int'(prev_te));
            end
        end
    end

    initial begin : driver
        int w;
        repeat (2) @(negedge TCK);
        #2;
        chk("rst_state", int'(state), int'(S_TLR));
        chk("rst_test_reset", int'(test_reset), 1);
        chk("rst_tdo_en", int'(tdo_en), 0);
        TRST = 1'b1;
        repeat (3) step(1'b1);

        // IR scan, shift hold, exit and update
        seq(16'b00110, 5);
        repeat (4) step(1'b0);
        seq(16'b11, 2);
        step(1'b0);

        // DR pause loop starting from RTI
        seq(16'b100101011, 9);
        step(1'b0);

        // Async reset mid DR shift, then hold TMS=1
        walk_to(S_SHDR);
        trst_pulse();
        repeat (3) step(1'b1);

        // Abort an IR scan: no update should follow
        walk_to(S_SHIR);
        trst_pulse();
        repeat (2) step(1'b1);

        // Five TMS=1 edges reach TLR from every state
        for (int s = 0; s < 16; s++) begin
            walk_to(4'(s));
            repeat (5) step(1'b1);
            chk("tlr_escape_model", int'(model), int'(S_TLR));
        end

        // Every state under both TMS values
        for (int s = 0; s < 16; s++) begin
            for (int t = 0; t < 2; t++) begin
                walk_to(4'(s));
                step(1'(t));
            end
        end

        // test_reset timing: leave TLR, return via SEL_IR
        repeat (5) step(1'b1);
        seq(16'b0111, 4);
        step(1'b1);

        repeat (400) step(1'($urandom_range(0, 1)));

        w = 0;
        while (q.size() > 0 && w < 10) begin
            @(negedge TCK);
            w++;
        end
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left", q.size());
        end
        @(negedge TCK);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
